// File: rtl/counter_pkg.sv
// Shared definitions for the parametrised up/down counter:
// run-mode codes, FSM states and the single-step helper.
package counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  // One step from cnt; term flags that cnt already sits at the terminal value.
  function automatic logic [31:0] next_count(
    input  logic [31:0] cnt,
    input  logic        up,
    input  logic [1:0]  mode,
    input  logic [31:0] maxc,
    output logic        term
  );
    logic [32:0] sum;
    term = up ? (cnt == maxc) : (cnt == 32'd0);
    sum  = up ? ({1'b0, cnt} + 33'd1) : ({1'b0, cnt} - 33'd1);
    if (!term)
      next_count = sum[31:0];
    else if (mode == MODE_SAT || mode == MODE_ONESHOT)
      next_count = cnt;
    else
      next_count = up ? 32'd0 : maxc;
  endfunction

endpackage

// File: rtl/param_updown_counter.sv
// WIDTH-bit up/down counter with programmable terminal value and
// wrap / saturate / one-shot run modes.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned MAX_COUNT = 4095,
  parameter logic [1:0]  MODE_RST  = 2'b00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("WIDTH must be in 2..32");
  end

  if (64'(MAX_COUNT) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $error("MAX_COUNT does not fit in WIDTH bits");
  end

  localparam logic [31:0]      MAXC32 = 32'(MAX_COUNT);
  localparam logic [WIDTH-1:0] MAXW   = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;

  logic [WIDTH-1:0] step;
  logic             term;
  logic [WIDTH-1:0] load_clamped;

  always_comb begin
    term = 1'b0;
    step = WIDTH'(next_count(32'(count_q), up_dn, mode_q, MAXC32, term));
  end

  assign load_clamped = (load_val > MAXW) ? MAXW : load_val;

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    done_d  = done_q;
    state_d = state_q;
    mode_d  = mode_q;
    if (clear) begin
      count_d = up_dn ? '0 : MAXW;
      state_d = ST_RUN;
      done_d  = 1'b0;
      mode_d  = mode;
    end else if (load) begin
      count_d = load_clamped;
      state_d = ST_RUN;
      done_d  = 1'b0;
      mode_d  = mode;
    end else if (en && state_q == ST_RUN) begin
      count_d = step;
      tc_d    = term;
      // one-shot parks at the terminal value until clear/load
      if (term && mode_q == MODE_ONESHOT) begin
        state_d = ST_HALT;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      state_q <= ST_RUN;
      mode_q  <= MODE_RST;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign done  = done_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter with a behavioural model
// compared every cycle plus literal spot checks.
module tb_param_updown_counter;

  localparam int MAXC = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        up_dn = 1'b1;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic [11:0] load_val = '0;
  logic [1:0]  mode = 2'b00;
  logic [11:0] count;
  logic        tc;
  logic        done;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  int m_cnt;
  bit m_tc, m_done, m_halt;
  int m_mode;

  param_updown_counter #(
    .WIDTH(12),
    .MAX_COUNT(MAXC),
    .MODE_RST(2'b00)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .up_dn(up_dn),
    .clear(clear),
    .load(load),
    .load_val(load_val),
    .mode(mode),
    .count(count),
    .tc(tc),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: mode rules expressed with plain integer arithmetic.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt = 0; m_tc = 0; m_done = 0; m_halt = 0; m_mode = 0;
    end else begin
      m_tc = 0;
      if (clear) begin
        m_cnt = up_dn ? 0 : MAXC;
        m_halt = 0; m_done = 0; m_mode = int'(mode);
      end else if (load) begin
        m_cnt = (int'(load_val) > MAXC) ? MAXC : int'(load_val);
        m_halt = 0; m_done = 0; m_mode = int'(mode);
      end else if (en && !m_halt) begin
        bit hit;
        hit = up_dn ? (m_cnt == MAXC) : (m_cnt == 0);
        m_tc = hit;
        if (m_mode == 1) begin
          m_cnt = up_dn ? ((m_cnt + 1 > MAXC) ? MAXC : m_cnt + 1)
                        : ((m_cnt - 1 < 0) ? 0 : m_cnt - 1);
        end else if (m_mode == 2) begin
          if (hit) begin
            m_halt = 1; m_done = 1;
          end else begin
            m_cnt = up_dn ? m_cnt + 1 : m_cnt - 1;
          end
        end else begin
          m_cnt = up_dn ? (m_cnt + 1) % (MAXC + 1)
                        : (m_cnt + MAXC) % (MAXC + 1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_count", count, m_cnt);
      chk("model_tc", tc, m_tc);
      chk("model_done", done, m_done);
    end
  end

  task automatic step(input logic e, input logic u, input logic c,
                      input logic l, input logic [11:0] lv,
                      input logic [1:0] md);
    @(negedge clk);
    en = e; up_dn = u; clear = c; load = l; load_val = lv; mode = md;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_tc", tc, 0);
    chk("rst_done", done, 0);
    chk_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // wrap up
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, 0, 0, 2'b00);
      if (i == 15) begin
        chk("wrap_cnt0", count, 0);
        chk("wrap_tc", tc, 1);
      end
      if (i == 19) chk("wrap_cnt4", count, 4);
    end

    // saturate down
    step(0, 0, 1, 0, 0, 2'b01);
    chk("sat_start", count, 15);
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 0, 0, 2'b00);
      if (i == 14) chk("sat_pre_tc", tc, 0);
      if (i == 15) begin
        chk("sat_hold", count, 0);
        chk("sat_tc1", tc, 1);
      end
      if (i == 19) chk("sat_tc_last", tc, 1);
    end
    step(0, 0, 0, 0, 0, 2'b00);
    chk("sat_en_low_tc", tc, 0);

    // one-shot
    step(0, 1, 1, 0, 0, 2'b10);
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, 0, 0, 2'b00);
      if (i == 15) begin
        chk("os_cnt", count, 15);
        chk("os_tc", tc, 1);
        chk("os_done", done, 1);
      end
      if (i == 19) begin
        chk("os_hold", count, 15);
        chk("os_tc_quiet", tc, 0);
      end
    end
    step(1, 1, 0, 1, 12'd3, 2'b10);
    chk("os_reload", count, 3);
    chk("os_done_clr", done, 0);
    step(1, 1, 0, 0, 0, 2'b00);
    chk("os_rerun", count, 4);

    // load clamp, clear beats load
    step(0, 1, 0, 1, 12'd40, 2'b00);
    chk("load_clamp", count, 15);
    step(0, 1, 1, 1, 12'd5, 2'b00);
    chk("clr_over_load", count, 0);

    // reserved mode behaves as wrap
    step(0, 0, 1, 0, 0, 2'b11);
    chk("rsv_start", count, 15);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 0, 0, 2'b00);
      if (i == 15) begin
        chk("rsv_wrap", count, 15);
        chk("rsv_tc", tc, 1);
      end
    end

    // async reset mid-count
    step(0, 1, 1, 0, 0, 2'b00);
    repeat (9) step(1, 1, 0, 0, 0, 2'b00);
    chk("pre_rst_cnt", count, 9);
    #2 reset = 1'b1;
    #1;
    chk("async_cnt", count, 0);
    chk("async_tc", tc, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_cnt", count, 3);

    // direction flip at terminal
    repeat (12) step(1, 1, 0, 0, 0, 2'b00);
    chk("flip_at15", count, 15);
    step(1, 0, 0, 0, 0, 2'b00);
    chk("flip_cnt", count, 14);
    chk("flip_no_tc", tc, 0);
    repeat (14) step(1, 0, 0, 0, 0, 2'b00);
    chk("down_to0", count, 0);
    step(1, 0, 0, 0, 0, 2'b00);
    chk("down_wrap", count, 15);
    chk("down_wrap_tc", tc, 1);

    step(0, 1, 0, 0, 0, 2'b00);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
